// File: rtl/ifetch_seq32_if.sv
// Fetch-unit bundle: execute-stage controls in, fetch results out, plus the
// instruction RAM read port.
interface ifetch_seq32_if #(
    parameter int unsigned ADDR_W = 14
);
    logic [31:0]       Addr_Result;
    logic              Zero;
    logic [31:0]       Read_data_1;
    logic              Branch;
    logic              nBranch;
    logic              Jmp;
    logic              Jal;
    logic              Jr;
    logic              stall;
    logic              upg_mode;
    logic [31:0]       imem_rdata;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       Instruction;
    logic [31:0]       PC_plus_4;
    logic [31:0]       link_addr;
    logic              instr_valid;
    logic              misalign_err;

    modport master (
        input  Addr_Result, Zero, Read_data_1, Branch, nBranch, Jmp, Jal, Jr,
               stall, upg_mode, imem_rdata,
        output imem_addr, Instruction, PC_plus_4, link_addr, instr_valid,
               misalign_err
    );

    modport slave (
        output Addr_Result, Zero, Read_data_1, Branch, nBranch, Jmp, Jal, Jr,
               stall, upg_mode, imem_rdata,
        input  imem_addr, Instruction, PC_plus_4, link_addr, instr_valid,
               misalign_err
    );
endinterface

// File: rtl/ifetch_seq32.sv
// Sequential instruction fetch for the 32-bit MIPS core: owns the PC, drives a
// 1-cycle-latency instruction RAM and yields it to the UART programmer.
module ifetch_seq32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 14
) (
    input  logic           clock,
    input  logic           reset,
    ifetch_seq32_if.master bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PROG  = 2'd1,
        ST_PRIME = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, next_pc, pc_plus_4;
    logic [XLEN-1:0] link_q, link_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;
    logic            br_taken;
    logic            jr_bad;

    assign pc_plus_4 = pc_q + XLEN'(4);
    assign br_taken  = (bus.Branch & bus.Zero) | (bus.nBranch & ~bus.Zero);
    assign jr_bad    = bus.Read_data_1[1:0] != 2'b00;

    // State register and PC; next_pc already holds the PC whenever it must not move
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            link_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= next_pc;
            valid_q    <= valid_d;
            link_q     <= link_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state, next-PC and flag logic
    always_comb begin
        state_d    = state_q;
        next_pc    = pc_q;
        valid_d    = valid_q;
        link_d     = link_q;
        misalign_d = misalign_q;

        case (state_q)
            ST_RUN: begin
                valid_d = 1'b1;
                if (bus.upg_mode) begin
                    state_d = ST_PROG;
                    valid_d = 1'b0;
                end else if (valid_q && !bus.stall) begin
                    if (bus.Jr) begin
                        if (jr_bad) begin
                            state_d    = ST_HALT;
                            valid_d    = 1'b0;
                            misalign_d = 1'b1;
                        end else begin
                            next_pc = bus.Read_data_1;
                        end
                    end else if (bus.Jmp || bus.Jal) begin
                        next_pc = {pc_plus_4[31:28], bus.imem_rdata[25:0], 2'b00};
                        if (bus.Jal) begin
                            link_d = pc_plus_4;
                        end
                    end else if (br_taken) begin
                        next_pc = bus.Addr_Result;
                    end else begin
                        next_pc = pc_plus_4;
                    end
                end
            end
            ST_PROG: begin
                valid_d = 1'b0;
                next_pc = RESET_PC;
                if (!bus.upg_mode) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                // Re-read the reset word so freshly programmed contents are fetched
                next_pc = RESET_PC;
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
            ST_HALT: begin
                valid_d    = 1'b0;
                misalign_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (reset) begin
            next_pc = RESET_PC;
        end
    end

    assign bus.imem_addr    = next_pc[ADDR_W+1:2];
    assign bus.Instruction  = bus.imem_rdata;
    assign bus.PC_plus_4    = pc_plus_4;
    assign bus.link_addr    = link_q;
    assign bus.instr_valid  = valid_q;
    assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_ifetch_seq32.sv
// Directed bench for ifetch_seq32: an architectural fetch model checked every
// cycle, plus literal expectations along the directed scenario.
module tb_ifetch_seq32;
    localparam int unsigned ADDR_W   = 14;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int M_RUN   = 0;
    localparam int M_PROG  = 1;
    localparam int M_PRIME = 2;
    localparam int M_HALT  = 3;

    logic clock;
    logic reset;
    logic [31:0] ram [0:255];

    int n_vec;
    int n_err;

    ifetch_seq32_if #(.ADDR_W(ADDR_W)) bus ();

    ifetch_seq32 #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous instruction RAM, one-cycle read latency
    always @(posedge clock) bus.imem_rdata <= ram[bus.imem_addr[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: where the PC goes and what the fetch flags read
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_link;
    bit          m_valid;
    bit          m_err;
    bit          live;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return ram[a[9:2]];
    endfunction

    function automatic bit acting();
        return !reset && m_mode == M_RUN && m_valid && !bus.stall && !bus.upg_mode;
    endfunction

    function automatic logic [31:0] model_next();
        logic [31:0] seq;
        logic [31:0] ins;
        seq = m_pc + 32'd4;
        ins = word_at(m_pc);
        if (reset || m_mode == M_PROG || m_mode == M_PRIME) return RESET_PC;
        if (!acting()) return m_pc;
        if (bus.Jr) return (bus.Read_data_1[1:0] != 2'b00) ? m_pc : bus.Read_data_1;
        if (bus.Jmp || bus.Jal) return {seq[31:28], ins[25:0], 2'b00};
        if ((bus.Branch && bus.Zero) || (bus.nBranch && !bus.Zero)) return bus.Addr_Result;
        return seq;
    endfunction

    always @(posedge clock) begin
        logic [31:0] np;
        bit          act;
        np  = model_next();
        act = acting();
        if (reset) begin
            m_mode = M_RUN;
            m_link = 32'd0;
            m_err  = 1'b0;
            live   = 1'b1;
        end else if (act && bus.Jr && bus.Read_data_1[1:0] != 2'b00) begin
            m_mode = M_HALT;
            m_err  = 1'b1;
        end else begin
            if (act && !bus.Jr && bus.Jal) m_link = m_pc + 32'd4;
            if (m_mode == M_RUN && bus.upg_mode) m_mode = M_PROG;
            else if (m_mode == M_PROG && !bus.upg_mode) m_mode = M_PRIME;
            else if (m_mode == M_PRIME) m_mode = M_RUN;
        end
        m_valid = !reset && m_mode == M_RUN;
        m_pc    = np;
    end

    // Every-cycle comparison against the model, mid-cycle
    always @(negedge clock) begin
        logic [31:0] np;
        if (live) begin
            np = model_next();
            check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
            check("pc_plus_4", bus.PC_plus_4, m_pc + 32'd4);
            check("link_addr", bus.link_addr, m_link);
            check("misalign_err", 32'(bus.misalign_err), 32'(m_err));
            check("imem_addr", 32'(bus.imem_addr), 32'(np[ADDR_W+1:2]));
            if (m_valid) check("instruction", bus.Instruction, word_at(m_pc));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl();
        bus.Addr_Result = 32'd0;
        bus.Zero        = 1'b0;
        bus.Read_data_1 = 32'd0;
        bus.Branch      = 1'b0;
        bus.nBranch     = 1'b0;
        bus.Jmp         = 1'b0;
        bus.Jal         = 1'b0;
        bus.Jr          = 1'b0;
        bus.stall       = 1'b0;
        bus.upg_mode    = 1'b0;
    endtask

    task automatic wait_pc(input logic [31:0] a);
        for (int i = 0; i < 200; i++) begin
            if (m_valid && m_pc == a) return;
            tick();
        end
        n_vec++;
        n_err++;
        $display("FAIL wait_pc: PC 0x%08h not reached, model at 0x%08h", a, m_pc);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        live  = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0000_0000;
        ram[8] = 32'h0C00_0040;
        ram[9] = 32'hA5A5_0009;
        clear_ctl();
        reset = 1'b1;

        // Reset, then straight-line fetch
        @(negedge clock);
        check("reset_imem_addr", 32'(bus.imem_addr), 32'd0);
        tick();
        reset = 1'b0;
        check("post_reset_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        check("first_valid", 32'(bus.instr_valid), 32'd1);
        check("seq_pc4_a", bus.PC_plus_4, 32'd4);
        check("seq_addr_a", 32'(bus.imem_addr), 32'd1);
        tick();
        check("seq_pc4_b", bus.PC_plus_4, 32'd8);
        check("seq_addr_b", 32'(bus.imem_addr), 32'd2);
        tick();
        check("seq_pc4_c", bus.PC_plus_4, 32'd12);
        check("seq_addr_c", 32'(bus.imem_addr), 32'd3);

        // beq / bne taken and not taken
        wait_pc(32'h10);
        bus.Branch = 1'b1; bus.Zero = 1'b1; bus.Addr_Result = 32'h40;
        tick(); clear_ctl();
        check("beq_taken", bus.PC_plus_4, 32'h44);
        bus.Branch = 1'b1; bus.Zero = 1'b1; bus.Addr_Result = 32'h10;
        tick(); clear_ctl();
        bus.Branch = 1'b1; bus.Zero = 1'b0; bus.Addr_Result = 32'h40;
        tick(); clear_ctl();
        check("beq_not_taken", bus.PC_plus_4, 32'h18);
        bus.nBranch = 1'b1; bus.Zero = 1'b0; bus.Addr_Result = 32'h10;
        tick(); clear_ctl();
        check("bne_taken", bus.PC_plus_4, 32'h14);
        bus.nBranch = 1'b1; bus.Zero = 1'b1; bus.Addr_Result = 32'h40;
        tick(); clear_ctl();
        check("bne_not_taken", bus.PC_plus_4, 32'h18);

        // jal then jr back to the link address
        wait_pc(32'h20);
        bus.Jal = 1'b1;
        tick(); clear_ctl();
        check("jal_target", bus.PC_plus_4, 32'h104);
        check("jal_link", bus.link_addr, 32'h24);
        bus.Jr = 1'b1; bus.Read_data_1 = 32'h24;
        tick(); clear_ctl();
        check("jr_target", bus.PC_plus_4, 32'h28);
        check("jr_link_held", bus.link_addr, 32'h24);

        // Stall masks a taken branch
        bus.stall = 1'b1; bus.Branch = 1'b1; bus.Zero = 1'b1; bus.Addr_Result = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc4", bus.PC_plus_4, 32'h28);
            check("stall_addr", 32'(bus.imem_addr), 32'd9);
            check("stall_instr", bus.Instruction, 32'hA5A5_0009);
        end
        clear_ctl();
        tick();
        check("stall_release", bus.PC_plus_4, 32'h2C);

        // Program mode entered at PC 0x80, RAM[0] rewritten meanwhile
        bus.Branch = 1'b1; bus.Zero = 1'b1; bus.Addr_Result = 32'h80;
        tick(); clear_ctl();
        check("pc_at_80", bus.PC_plus_4, 32'h84);
        bus.upg_mode = 1'b1;
        tick();
        check("prog_valid", 32'(bus.instr_valid), 32'd0);
        check("prog_pc_held", bus.PC_plus_4, 32'h84);
        ram[0] = 32'h1234_5678;
        tick(); tick();
        bus.upg_mode = 1'b0;
        tick();
        check("prime_valid", 32'(bus.instr_valid), 32'd0);
        check("prime_addr", 32'(bus.imem_addr), 32'd0);
        tick();
        check("resume_valid", 32'(bus.instr_valid), 32'd1);
        check("resume_pc4", bus.PC_plus_4, RESET_PC + 32'd4);
        check("resume_instr", bus.Instruction, 32'h1234_5678);

        // Misaligned jr halts until reset, upg_mode ignored
        bus.Jr = 1'b1; bus.Read_data_1 = 32'h26;
        tick(); clear_ctl();
        check("halt_err", 32'(bus.misalign_err), 32'd1);
        check("halt_valid", 32'(bus.instr_valid), 32'd0);
        check("halt_pc4", bus.PC_plus_4, 32'd4);
        for (int i = 0; i < 10; i++) begin
            bus.upg_mode = i[0];
            bus.Branch   = 1'b1;
            bus.Zero     = 1'b1;
            tick();
        end
        clear_ctl();
        check("halt_frozen_pc4", bus.PC_plus_4, 32'd4);
        check("halt_frozen_err", 32'(bus.misalign_err), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_clears_err", 32'(bus.misalign_err), 32'd0);
        check("reset_clears_link", bus.link_addr, 32'd0);
        tick();
        check("rerun_valid", 32'(bus.instr_valid), 32'd1);

        // Jr beats Jal; PC wraps from 0xFFFF_FFFC; Jmp beats Branch
        bus.Jr = 1'b1; bus.Jal = 1'b1; bus.Read_data_1 = 32'hFFFF_FFFC;
        tick(); clear_ctl();
        check("wrap_pc4", bus.PC_plus_4, 32'd0);
        check("jr_over_jal_link", bus.link_addr, 32'd0);
        tick();
        check("wrap_to_zero", bus.PC_plus_4, 32'd4);
        bus.Jmp = 1'b1; bus.Branch = 1'b1; bus.Zero = 1'b1; bus.Addr_Result = 32'h40;
        tick(); clear_ctl();
        check("jmp_over_branch", bus.PC_plus_4, 32'h08D1_59E4);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
